// File: rtl/scan_shift_ctrl.sv
// scan_shift_ctrl
//   Drives one load/unload run of a scan chain. The chain is loaded MSB first
//   from a latched pattern and the previous chain contents are unloaded from
//   so at the same time. An optional capture cycle follows the shift. The
//   unloaded vector can be compared against a latched reference.
//
// Ports
//   sclk            clock; all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   start           request a run; honoured only in IDLE without abort
//   abort           terminate a run in SHIFT or CAPTURE
//   pattern         vector to shift in, MSB first
//   expected        reference for the unloaded vector
//   compare_en      compare the unloaded vector against expected
//   capture_en      insert one capture cycle (se=0) after the shift
//   so              scan-out from the chain
//   se, si          registered scan enable / scan-in to the chain
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of a completed run
//   pass            run result, valid from done until the next accepted start
//   unload          vector sampled from so, MSB first
//   mismatch_mask   unload ^ expected, or 0 when compare is disabled
//   mismatch_count  number of set bits in mismatch_mask
module scan_shift_ctrl #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                           sclk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [CHAIN_LEN-1:0]           pattern,
  input  logic [CHAIN_LEN-1:0]           expected,
  input  logic                           compare_en,
  input  logic                           capture_en,
  input  logic                           so,
  output logic                           se,
  output logic                           si,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [CHAIN_LEN-1:0]           unload,
  output logic [CHAIN_LEN-1:0]           mismatch_mask,
  output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_count
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam int POP_W = $clog2(CHAIN_LEN+1);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(CHAIN_LEN-1);
  localparam logic [CHAIN_LEN-1:0] MSB_ONE  = {1'b1, {(CHAIN_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 se_d, si_d;

  logic [CHAIN_LEN-1:0] pat_q, exp_q;
  logic                 cmp_en_q, cap_en_q;

  logic                 accept;
  logic                 last_bit;
  logic [CHAIN_LEN-1:0] pat_src, pat_shl;
  logic [CHAIN_LEN-1:0] bit_sel;
  logic [CHAIN_LEN-1:0] unload_nx;
  logic [CHAIN_LEN-1:0] mask_nx;
  logic [POP_W-1:0]     pop_nx;
  logic                 pass_nx;

  function automatic logic [POP_W-1:0] popcount(input logic [CHAIN_LEN-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      c = c + {{(POP_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // abort outranks start in IDLE, so a simultaneous pair starts nothing
  assign accept   = (state_q == IDLE) && start && !abort;
  assign last_bit = (bit_cnt_q == LAST_BIT);

  // ---- state register ----
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      se        <= 1'b0;
      si        <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      se        <= se_d;
      si        <= si_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)         state_d = IDLE;
        else if (last_bit) state_d = cap_en_q ? CAPTURE : DONE;
      end
      CAPTURE: begin
        state_d = abort ? IDLE : DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Counter restarts at 0 on entry and leaves SHIFT at LAST_BIT, so it
    // never wraps inside a run.
    if (state_q == SHIFT && state_d == SHIFT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
  end

  // ---- output logic ----
  // se/si are computed for the state being entered and registered, so they
  // are stable for the whole cycle of that state. On the accept edge the
  // pattern is still on the input port, not yet in pat_q.
  always_comb begin
    pat_src = (state_q == IDLE) ? pattern : pat_q;
    pat_shl = pat_src << bit_cnt_d;
    se_d    = 1'b0;
    si_d    = 1'b0;
    if (state_d == SHIFT) begin
      se_d = 1'b1;
      si_d = pat_shl[CHAIN_LEN-1];
    end
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // ---- run configuration, captured on accept ----
  always_ff @(posedge sclk) begin
    if (accept) begin
      pat_q    <= pattern;
      exp_q    <= expected;
      cmp_en_q <= compare_en;
      cap_en_q <= capture_en;
    end
  end

  // so in shift cycle k lands in unload[CHAIN_LEN-1-k]
  always_comb begin
    bit_sel   = MSB_ONE >> bit_cnt_q;
    unload_nx = so ? (unload | bit_sel) : (unload & ~bit_sel);
    mask_nx   = cmp_en_q ? (unload_nx ^ exp_q) : '0;
    pop_nx    = popcount(mask_nx);
    // Coming straight from SHIFT the count is being formed on this edge;
    // coming from CAPTURE it is already registered.
    pass_nx   = !cmp_en_q ||
                (((state_q == SHIFT) ? pop_nx : mismatch_count) == '0);
  end

  // ---- result registers ----
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      unload         <= '0;
      mismatch_mask  <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      unload         <= '0;
      mismatch_mask  <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (abort) begin
            pass <= 1'b0;
          end else begin
            unload <= unload_nx;
            if (last_bit) begin
              mismatch_mask  <= mask_nx;
              mismatch_count <= pop_nx;
              if (!cap_en_q) pass <= pass_nx;
            end
          end
        end
        CAPTURE: begin
          pass <= abort ? 1'b0 : pass_nx;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_shift_ctrl.sv
module tb_scan_shift_ctrl;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [7:0] expected;
  logic       compare_en;
  logic       capture_en;
  logic       so;
  logic       se;
  logic       si;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] unload;
  logic [7:0] mismatch_mask;
  logic [3:0] mismatch_count;

  int n_cmp = 0;
  int n_bad = 0;

  // external 8-flop scan chain: shifts toward the MSB when se is high
  logic [7:0] chain = 8'h3C;
  assign so = chain[7];
  always @(posedge sclk) if (se) chain <= {chain[6:0], si};

  always #5 sclk = ~sclk;

  scan_shift_ctrl #(.CHAIN_LEN(8)) dut (
    .sclk          (sclk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pattern       (pattern),
    .expected      (expected),
    .compare_en    (compare_en),
    .capture_en    (capture_en),
    .so            (so),
    .se            (se),
    .si            (si),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .unload        (unload),
    .mismatch_mask (mismatch_mask),
    .mismatch_count(mismatch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_se"},     32'(se),             32'd0);
    chk({tag, "_si"},     32'(si),             32'd0);
    chk({tag, "_busy"},   32'(busy),           32'd0);
    chk({tag, "_done"},   32'(done),           32'd0);
    chk({tag, "_pass"},   32'(pass),           32'd0);
    chk({tag, "_unload"}, 32'(unload),         32'd0);
    chk({tag, "_mask"},   32'(mismatch_mask),  32'd0);
    chk({tag, "_count"},  32'(mismatch_count), 32'd0);
  endtask

  // One run from IDLE, called at a falling edge. abort_k / rst_k select the
  // shift cycle in which to abort or reset (-1 for none); poke drives start
  // during the run and on the done cycle, which must all be ignored.
  task automatic run(input logic [7:0] pat, input logic [7:0] exp_v,
                     input logic cmp, input logic cap,
                     input int abort_k, input int rst_k, input logic poke);
    logic [7:0] snap, exp_mask, shl, partial;
    logic [3:0] exp_cnt;
    logic       exp_pass;
    pattern = pat; expected = exp_v; compare_en = cmp; capture_en = cap;
    start = 1'b1;
    snap  = chain;                       // the run must unload exactly this
    exp_mask = cmp ? (snap ^ exp_v) : 8'h00;
    exp_cnt  = 4'($countones(exp_mask));
    exp_pass = (exp_cnt == 4'd0);
    @(negedge sclk);
    start = 1'b0;
    // change the inputs so that only the latched copies can be in use
    pattern = ~pat; expected = ~exp_v; compare_en = ~cmp; capture_en = ~cap;
    for (int c = 1; c <= 8; c++) begin
      shl = pat << (c - 1);
      chk("shift_busy", 32'(busy), 32'd1);
      chk("shift_se",   32'(se),   32'd1);
      chk("shift_si",   32'(si),   32'(shl[7]));
      chk("shift_done", 32'(done), 32'd0);
      if (c - 1 == abort_k) begin
        abort = 1'b1;
        start = 1'b0;
        @(negedge sclk);
        abort = 1'b0;
        partial = snap & ~(8'hFF >> abort_k);
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_se",     32'(se),     32'd0);
        chk("abort_si",     32'(si),     32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_pass",   32'(pass),   32'd0);
        chk("abort_unload", 32'(unload), 32'(partial));
        @(negedge sclk);
        chk("abort_no_done", 32'(done), 32'd0);
        return;
      end
      if (c - 1 == rst_k) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge sclk);
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        return;
      end
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge sclk);
    end
    start = 1'b0;
    if (cap) begin
      chk("cap_se",   32'(se),   32'd0);
      chk("cap_si",   32'(si),   32'd0);
      chk("cap_busy", 32'(busy), 32'd1);
      chk("cap_done", 32'(done), 32'd0);
      @(negedge sclk);
    end
    chk("done_pulse",  32'(done),           32'd1);
    chk("done_busy",   32'(busy),           32'd1);
    chk("done_se",     32'(se),             32'd0);
    chk("done_si",     32'(si),             32'd0);
    chk("done_unload", 32'(unload),         32'(snap));
    chk("done_mask",   32'(mismatch_mask),  32'(exp_mask));
    chk("done_count",  32'(mismatch_count), 32'(exp_cnt));
    chk("done_pass",   32'(pass),           32'(exp_pass));
    start = poke;                        // start alongside done is ignored
    @(negedge sclk);
    start = 1'b0;
    chk("post_done",   32'(done),           32'd0);
    chk("post_busy",   32'(busy),           32'd0);
    chk("hold_unload", 32'(unload),         32'(snap));
    chk("hold_count",  32'(mismatch_count), 32'(exp_cnt));
    chk("hold_pass",   32'(pass),           32'(exp_pass));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = 8'h00; expected = 8'h00; compare_en = 1'b0; capture_en = 1'b0;
    #3 chk_all_zero("reset");
    @(negedge sclk); @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);

    // all-ones load, no compare: 8 shift cycles of si=1, done in cycle 9
    run(8'hFF, 8'h00, 1'b0, 1'b0, -1, -1, 1'b0);
    // chain now all ones; compare against FF
    run(8'h00, 8'hFF, 1'b1, 1'b0, -1, -1, 1'b0);
    // load A5, then unload it against 0F
    run(8'hA5, 8'h00, 1'b0, 1'b0, -1, -1, 1'b0);
    run(8'h3C, 8'h0F, 1'b1, 1'b0, -1, -1, 1'b0);
    // capture cycle between shift and done, with start pokes
    run(8'($urandom), 8'($urandom), 1'b1, 1'b1, -1, -1, 1'b1);

    // abort wins over start in IDLE
    abort = 1'b1; start = 1'b1;
    @(negedge sclk);
    abort = 1'b0; start = 1'b0;
    chk("abort_vs_start", 32'(busy), 32'd0);

    // abort in shift cycle 3 with start pokes
    run(8'h96, 8'h00, 1'b1, 1'b0, 3, -1, 1'b1);
    // reset in shift cycle 5, then a full run
    run(8'h5A, 8'h00, 1'b1, 1'b1, -1, 5, 1'b0);
    run(8'hC3, 8'h33, 1'b1, 1'b0, -1, -1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      run(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
          -1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_shift_ctrl.md
SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

Interface
REQ-001 SHALL have parameter: CHAIN_LEN, default 8, scan chain length in flops, legal range 2..64.
REQ-002 SHALL have port: sclk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request one load/unload run; honoured only in IDLE.
REQ-005 SHALL have port: abort  input  1  terminate the current run.
REQ-006 SHALL have port: pattern  input  CHAIN_LEN  vector to shift in, MSB first.
REQ-007 SHALL have port: expected  input  CHAIN_LEN  reference for the unloaded vector.
REQ-008 SHALL have port: compare_en  input  1  enable compare for this run.
REQ-009 SHALL have port: capture_en  input  1  insert one capture cycle after shift.
REQ-010 SHALL have port: so  input  1  scan-out from the chain.
REQ-011 SHALL have port: se  output  1  scan enable to the chain; registered.
REQ-012 SHALL have port: si  output  1  scan-in to the chain; registered.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at the end of a completed run.
REQ-015 SHALL have port: pass  output  1  run result; valid from done onward.
REQ-016 SHALL have port: unload  output  CHAIN_LEN  vector captured from so.
REQ-017 SHALL have port: mismatch_mask  output  CHAIN_LEN  unload XOR expected, or 0 when compare_en=0.
REQ-018 SHALL have port: mismatch_count  output  $clog2(CHAIN_LEN+1)  popcount of mismatch_mask.

Function
REQ-019 SHALL implement the states IDLE, SHIFT, CAPTURE and DONE.
REQ-020 IDLE with start=1 at an edge SHALL latch pattern, expected, compare_en and capture_en, clear unload, mismatch_mask, mismatch_count and pass, load bit counter=0, and enter SHIFT.
REQ-021 SHIFT SHALL last exactly CHAIN_LEN cycles, with se=1 and si=latched pattern[CHAIN_LEN-1-k] in shift cycle k (k=0..CHAIN_LEN-1).
REQ-022 At the edge ending shift cycle k, the block SHALL sample so into unload[CHAIN_LEN-1-k]; unload therefore equals the chain contents before the run, MSB first.
REQ-023 After the last shift cycle the block SHALL enter CAPTURE if capture_en was latched, otherwise DONE.
REQ-024 CAPTURE SHALL be exactly 1 cycle with se=0 and si=0, then DONE.
REQ-025 DONE SHALL be exactly 1 cycle with done=1, se=0 and si=0, then IDLE.
REQ-026 In DONE, mismatch_mask, mismatch_count and pass SHALL be valid; pass=(mismatch_count==0), forced to 1 when compare_en=0.
REQ-027 All result outputs SHALL hold their values until the next accepted start.
REQ-028 A start asserted while busy=1 SHALL be ignored with no queuing.
REQ-029 start asserted in the same cycle as done SHALL be ignored; it is accepted only from IDLE.
REQ-030 An abort sampled in SHIFT or CAPTURE SHALL cause IDLE at the next edge with se=0 and si=0, no done pulse, pass=0, and unload holding the partial bits.
REQ-031 abort SHALL have priority over start in IDLE; start is then not accepted.
REQ-032 The bit counter SHALL be $clog2(CHAIN_LEN) bits wide, terminate at CHAIN_LEN-1 and never wrap mid-run.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and set se=0, si=0, busy=0, done=0, pass=0, unload=0, mismatch_mask=0, mismatch_count=0 and bit counter=0, including mid-SHIFT.
REQ-034 After rst_n deasserts, the first start SHALL be accepted normally.

Verification (CHAIN_LEN=8, chain model = 8-flop shift register on sclk)
REQ-035 Scenario: reset, then start with pattern=8'hFF, compare_en=0, capture_en=0 -> se=1 for exactly 8 cycles, si=1 each cycle, done in cycle 9 after accept, pass=1.
REQ-036 Scenario: start with pattern=8'h00, expected=8'hFF, compare_en=1 -> unload=8'hFF, mismatch_count=0, pass=1.
REQ-037 Scenario: chain holding 8'hA5, start with expected=8'h0F, compare_en=1 -> unload=8'hA5, mismatch_mask=8'hAA, mismatch_count=4, pass=0.
REQ-038 Scenario: capture_en=1 -> a single se=0 cycle between the last shift and done; done in cycle 10 after accept.
REQ-039 Scenario: abort in shift cycle 3 -> IDLE next edge, no done, busy=0; start pulses during the run are ignored.
REQ-040 Scenario: rst_n low in shift cycle 5 -> all outputs 0 asynchronously; after release a full run completes correctly.
